// File: rtl/mii_udp_receiver.sv
// MII receiver: filters Ethernet/IPv4/UDP frames by MAC, IP and port, checks FCS,
// and reports the first 4 payload bytes. Optional frame statistics under RX_STATS_EN.
module mii_udp_receiver #(
    parameter logic [47:0] MyMAC   = 48'h123456789ABC,
    parameter logic [31:0] MyIP    = 32'hC0A82518,
    parameter logic [15:0] UDPport = 16'd1024
) (
    input  logic        i_clk,
    input  logic        i_res_n,
    input  logic        i_mii_rx_dv,
    input  logic        i_mii_rx_er,
    input  logic [3:0]  i_mii_rxd,
    output logic        o_rx_valid,
    output logic [31:0] o_rx_data,
    output logic        o_rx_err,
    output logic [15:0] o_good_cnt,
    output logic [15:0] o_err_cnt
);

    typedef enum logic [1:0] {IDLE, PREAMBLE, DATA, DROP} state_t;

    state_t      state, state_nxt;
    logic [3:0]  lo_nib;
    logic        nib_phase;
    logic [10:0] byte_cnt;
    logic [31:0] crc;
    logic        er_seen, oversize;
    logic        mac_my_ok, mac_bc_ok, hdr_ok;
    logic [31:0] shadow;
    logic        pend_valid, pend_err;

    logic [7:0]  rx_byte, mac_exp, hdr_exp;
    logic        byte_done, frame_end, too_long, hdr_chk;
    logic        frame_ok, hdr_pass, drop_end_over;

    // Reflected CRC-32, one nibble per clock, LSB first.
    function automatic logic [31:0] crc_nib(input logic [31:0] c, input logic [3:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 4; i++) begin
            if (r[0] ^ d[i]) r = {1'b0, r[31:1]} ^ 32'hEDB88320;
            else             r = {1'b0, r[31:1]};
        end
        return r;
    endfunction

    assign rx_byte       = {i_mii_rxd, lo_nib};
    assign byte_done     = (state == DATA) && i_mii_rx_dv && nib_phase;
    assign frame_end     = (state == DATA) && !i_mii_rx_dv;
    assign too_long      = byte_done && (byte_cnt == 11'd1518);
    assign frame_ok      = !er_seen && !nib_phase && (byte_cnt >= 11'd64) && (crc == 32'hDEBB20E3);
    assign hdr_pass      = (mac_my_ok || mac_bc_ok) && hdr_ok;
    assign drop_end_over = (state == DROP) && !i_mii_rx_dv && oversize;

    // NOTE: state register is sequential and uses non-blocking assignment; all
    // combinational logic below uses blocking assignment.
    always_ff @(posedge i_clk or negedge i_res_n) begin
        if (!i_res_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        // NOTE: default assigned first so no path through the case infers a latch.
        state_nxt = state;
        case (state)
            IDLE:     if (i_mii_rx_dv) state_nxt = (i_mii_rxd == 4'h5) ? PREAMBLE : DROP;
            PREAMBLE: begin
                if (!i_mii_rx_dv)            state_nxt = IDLE;
                else if (i_mii_rxd == 4'hD)  state_nxt = DATA;
                else if (i_mii_rxd != 4'h5)  state_nxt = DROP;
            end
            DATA: begin
                if (!i_mii_rx_dv)  state_nxt = IDLE;
                else if (too_long) state_nxt = DROP;
            end
            DROP:     if (!i_mii_rx_dv) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Expected header byte at the current byte position.
    always_comb begin
        mac_exp = 8'h00;
        hdr_exp = 8'h00;
        hdr_chk = 1'b0;
        case (byte_cnt)
            11'd0:  mac_exp = MyMAC[47:40];
            11'd1:  mac_exp = MyMAC[39:32];
            11'd2:  mac_exp = MyMAC[31:24];
            11'd3:  mac_exp = MyMAC[23:16];
            11'd4:  mac_exp = MyMAC[15:8];
            11'd5:  mac_exp = MyMAC[7:0];
            11'd12: begin hdr_exp = 8'h08;          hdr_chk = 1'b1; end
            11'd13: begin hdr_exp = 8'h00;          hdr_chk = 1'b1; end
            11'd14: begin hdr_exp = 8'h45;          hdr_chk = 1'b1; end
            11'd23: begin hdr_exp = 8'h11;          hdr_chk = 1'b1; end
            11'd30: begin hdr_exp = MyIP[31:24];    hdr_chk = 1'b1; end
            11'd31: begin hdr_exp = MyIP[23:16];    hdr_chk = 1'b1; end
            11'd32: begin hdr_exp = MyIP[15:8];     hdr_chk = 1'b1; end
            11'd33: begin hdr_exp = MyIP[7:0];      hdr_chk = 1'b1; end
            11'd36: begin hdr_exp = UDPport[15:8];  hdr_chk = 1'b1; end
            11'd37: begin hdr_exp = UDPport[7:0];   hdr_chk = 1'b1; end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_res_n) begin
        if (!i_res_n) begin
            lo_nib     <= '0;
            nib_phase  <= 1'b0;
            byte_cnt   <= '0;
            crc        <= 32'hFFFFFFFF;
            er_seen    <= 1'b0;
            oversize   <= 1'b0;
            mac_my_ok  <= 1'b1;
            mac_bc_ok  <= 1'b1;
            hdr_ok     <= 1'b1;
            shadow     <= '0;
            pend_valid <= 1'b0;
            pend_err   <= 1'b0;
            o_rx_valid <= 1'b0;
            o_rx_err   <= 1'b0;
            o_rx_data  <= '0;
        end else begin
            // Verdict is registered at frame end and presented one edge later.
            pend_valid <= frame_end && frame_ok && hdr_pass;
            pend_err   <= (frame_end && !frame_ok) || drop_end_over;
            o_rx_valid <= pend_valid;
            o_rx_err   <= pend_err;
            if (pend_valid) o_rx_data <= shadow;

            if (state != DATA) begin
                nib_phase <= 1'b0;
                byte_cnt  <= '0;
                crc       <= 32'hFFFFFFFF;
                er_seen   <= 1'b0;
                mac_my_ok <= 1'b1;
                mac_bc_ok <= 1'b1;
                hdr_ok    <= 1'b1;
            end else if (i_mii_rx_dv) begin
                crc       <= crc_nib(crc, i_mii_rxd);
                nib_phase <= ~nib_phase;
                if (i_mii_rx_er) er_seen <= 1'b1;
                if (!nib_phase) begin
                    lo_nib <= i_mii_rxd;
                end else begin
                    byte_cnt <= byte_cnt + 11'd1;
                    if (byte_cnt < 11'd6) begin
                        if (rx_byte != mac_exp) mac_my_ok <= 1'b0;
                        if (rx_byte != 8'hFF)   mac_bc_ok <= 1'b0;
                    end
                    if (hdr_chk && (rx_byte != hdr_exp)) hdr_ok <= 1'b0;
                    case (byte_cnt)
                        11'd42: shadow[31:24] <= rx_byte;
                        11'd43: shadow[23:16] <= rx_byte;
                        11'd44: shadow[15:8]  <= rx_byte;
                        11'd45: shadow[7:0]   <= rx_byte;
                        default: ;
                    endcase
                end
            end

            if (state == IDLE)  oversize <= 1'b0;
            else if (too_long)  oversize <= 1'b1;
        end
    end

`ifdef RX_STATS_EN
    logic [15:0] good_cnt, err_cnt;

    always_ff @(posedge i_clk or negedge i_res_n) begin
        if (!i_res_n) begin
            good_cnt <= '0;
            err_cnt  <= '0;
        end else begin
            if (pend_valid && (good_cnt != 16'hFFFF)) good_cnt <= good_cnt + 16'd1;
            if (pend_err && (err_cnt != 16'hFFFF))    err_cnt  <= err_cnt + 16'd1;
        end
    end

    assign o_good_cnt = good_cnt;
    assign o_err_cnt  = err_cnt;
`else
    assign o_good_cnt = '0;
    assign o_err_cnt  = '0;
`endif

endmodule

// File: tb/tb_mii_udp_receiver.sv
// Directed bench for mii_udp_receiver: builds MII frames, checks pulses, payload
// and (when RX_STATS_EN is defined) the frame counters.
module tb_mii_udp_receiver;

    logic        clk = 1'b0;
    logic        res_n;
    logic        rx_dv, rx_er;
    logic [3:0]  rxd;
    logic        rx_valid, rx_err;
    logic [31:0] rx_data;
    logic [15:0] good_cnt, err_cnt;

    int n_checks = 0;
    int n_pass   = 0;
    int n_valid  = 0;
    int n_err    = 0;

    logic [7:0] fr [0:1599];
    int         fr_len;

    mii_udp_receiver dut (
        .i_clk       (clk),
        .i_res_n     (res_n),
        .i_mii_rx_dv (rx_dv),
        .i_mii_rx_er (rx_er),
        .i_mii_rxd   (rxd),
        .o_rx_valid  (rx_valid),
        .o_rx_data   (rx_data),
        .o_rx_err    (rx_err),
        .o_good_cnt  (good_cnt),
        .o_err_cnt   (err_cnt)
    );

    always #20 clk = ~clk;

    // Count result pulses shortly after each active edge.
    always @(posedge clk) begin
        #1;
        if (rx_valid) n_valid++;
        if (rx_err)   n_err++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic nib(input logic dv, input logic er, input logic [3:0] d);
        @(negedge clk);
        rx_dv = dv;
        rx_er = er;
        rxd   = d;
    endtask

    task automatic end_frame();
        nib(1'b0, 1'b0, 4'h0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    // mac_sel: 0 broadcast, 1 own MAC, 2 foreign MAC. len includes the 4-byte FCS.
    task automatic build(input int mac_sel, input logic [15:0] port, input logic [31:0] pay, input int len);
        logic [47:0] mac;
        logic [31:0] c;
        mac = (mac_sel == 0) ? 48'hFFFFFFFFFFFF : (mac_sel == 1) ? 48'h123456789ABC : 48'h123456789ABD;
        fr_len = len;
        for (int i = 0; i < len; i++) fr[i] = 8'h00;
        for (int i = 0; i < 6; i++) fr[i] = mac[47-8*i -: 8];
        fr[6] = 8'h02; fr[11] = 8'h01;
        fr[12] = 8'h08; fr[13] = 8'h00; fr[14] = 8'h45; fr[17] = 8'h32;
        fr[22] = 8'h40; fr[23] = 8'h11;
        fr[26] = 8'hC0; fr[27] = 8'hA8; fr[28] = 8'h25; fr[29] = 8'h01;
        fr[30] = 8'hC0; fr[31] = 8'hA8; fr[32] = 8'h25; fr[33] = 8'h18;
        fr[34] = 8'h04; fr[35] = 8'h00; fr[36] = port[15:8]; fr[37] = port[7:0];
        fr[39] = 8'h1E;
        fr[42] = pay[31:24]; fr[43] = pay[23:16]; fr[44] = pay[15:8]; fr[45] = pay[7:0];
        c = 32'hFFFFFFFF;
        for (int i = 0; i < len - 4; i++) c = crc_byte(c, fr[i]);
        c = ~c;
        fr[len-4] = c[7:0]; fr[len-3] = c[15:8]; fr[len-2] = c[23:16]; fr[len-1] = c[31:24];
    endtask

    // Preamble + SFD, then n_bytes of fr[] (rx_dv left high afterwards).
    task automatic send_frame(input int er_byte, input bit flip_last, input bit extra_nib, input int n_bytes);
        logic [3:0] hi;
        for (int i = 0; i < 15; i++) nib(1'b1, 1'b0, 4'h5);
        nib(1'b1, 1'b0, 4'hD);
        for (int i = 0; i < n_bytes; i++) begin
            hi = fr[i][7:4];
            if (flip_last && (i == n_bytes - 1)) hi = hi ^ 4'h1;
            nib(1'b1, (i == er_byte), fr[i][3:0]);
            nib(1'b1, 1'b0, hi);
        end
        if (extra_nib) nib(1'b1, 1'b0, 4'h0);
    endtask

    initial begin
        res_n = 1'b0;
        rx_dv = 1'b0;
        rx_er = 1'b0;
        rxd   = 4'h0;
        idle(3);
        check("reset_valid", {31'b0, rx_valid}, 32'd0);
        check("reset_err",   {31'b0, rx_err},   32'd0);
        check("reset_data",  rx_data,           32'd0);
        check("reset_good",  {16'b0, good_cnt}, 32'd0);
        check("reset_errc",  {16'b0, err_cnt},  32'd0);
        res_n = 1'b1;
        idle(2);

        // Good broadcast frame: exact pulse timing and payload.
        build(0, 16'd1024, 32'hDEADBEEF, 64);
        send_frame(-1, 1'b0, 1'b0, 64);
        end_frame();
        @(negedge clk);
        check("lat_early_valid", {31'b0, rx_valid}, 32'd0);
        check("lat_early_data",  rx_data,           32'd0);
        @(negedge clk);
        check("lat_pulse_valid", {31'b0, rx_valid}, 32'd1);
        check("lat_pulse_err",   {31'b0, rx_err},   32'd0);
        check("lat_pulse_data",  rx_data,           32'hDEADBEEF);
        @(negedge clk);
        check("pulse_width",     {31'b0, rx_valid}, 32'd0);
        idle(2);
        check("good_nvalid", n_valid, 32'd1);
        check("good_nerr",   n_err,   32'd0);

        // Same frame, last FCS nibble corrupted.
        send_frame(-1, 1'b1, 1'b0, 64);
        end_frame(); idle(4);
        check("badfcs_nerr",   n_err,   32'd1);
        check("badfcs_nvalid", n_valid, 32'd1);
        check("badfcs_data",   rx_data, 32'hDEADBEEF);

        // Wrong UDP port: silently dropped.
        build(0, 16'd1025, 32'hDEADBEEF, 64);
        send_frame(-1, 1'b0, 1'b0, 64);
        end_frame(); idle(4);
        check("port_nvalid", n_valid, 32'd1);
        check("port_nerr",   n_err,   32'd1);

        // rx_er for one nibble at byte 20.
        build(0, 16'd1024, 32'hDEADBEEF, 64);
        send_frame(20, 1'b0, 1'b0, 64);
        end_frame(); idle(4);
        check("rxer_nerr",   n_err,   32'd2);
        check("rxer_nvalid", n_valid, 32'd1);

        // Unicast to own MAC, then to a foreign MAC.
        build(1, 16'd1024, 32'h01020304, 64);
        send_frame(-1, 1'b0, 1'b0, 64);
        end_frame(); idle(4);
        check("ucast_nvalid", n_valid, 32'd2);
        check("ucast_data",   rx_data, 32'h01020304);
        build(2, 16'd1024, 32'hAAAAAAAA, 64);
        send_frame(-1, 1'b0, 1'b0, 64);
        end_frame(); idle(4);
        check("othermac_nvalid", n_valid, 32'd2);
        check("othermac_nerr",   n_err,   32'd2);
        check("othermac_data",   rx_data, 32'h01020304);

        // 60-byte runt with valid FCS.
        build(0, 16'd1024, 32'hDEADBEEF, 60);
        send_frame(-1, 1'b0, 1'b0, 60);
        end_frame(); idle(4);
        check("runt_nerr", n_err, 32'd3);

        // 1600-byte frame: error only after rx_dv falls.
        build(0, 16'd1024, 32'hDEADBEEF, 1600);
        send_frame(-1, 1'b0, 1'b0, 1600);
        check("long_nerr_before_end", n_err, 32'd3);
        end_frame(); idle(4);
        check("long_nerr", n_err,   32'd4);
        check("long_nvalid", n_valid, 32'd2);

        // Good 64-byte frame plus one stray nibble (129 nibbles).
        build(0, 16'd1024, 32'hDEADBEEF, 64);
        send_frame(-1, 1'b0, 1'b1, 64);
        end_frame(); idle(4);
        check("oddnib_nerr",   n_err,   32'd5);
        check("oddnib_nvalid", n_valid, 32'd2);
`ifdef RX_STATS_EN
        check("stats_good_a", {16'b0, good_cnt}, 32'd2);
        check("stats_err_a",  {16'b0, err_cnt},  32'd5);
`else
        check("stats_good_a", {16'b0, good_cnt}, 32'd0);
        check("stats_err_a",  {16'b0, err_cnt},  32'd0);
`endif

        // Reset at byte 30, released while rx_dv is high mid-frame.
        build(0, 16'd1024, 32'h12121212, 64);
        send_frame(-1, 1'b0, 1'b0, 30);
        @(negedge clk);
        res_n = 1'b0;
        #1;
        check("midreset_data", rx_data,           32'd0);
        check("midreset_good", {16'b0, good_cnt}, 32'd0);
        check("midreset_errc", {16'b0, err_cnt},  32'd0);
        @(negedge clk);
        res_n = 1'b1;
        rxd   = 4'hA;
        for (int i = 0; i < 6; i++) nib(1'b1, 1'b0, 4'h3);
        end_frame(); idle(4);
        check("midreset_nvalid", n_valid, 32'd2);
        check("midreset_nerr",   n_err,   32'd5);
        build(0, 16'd1024, 32'hCAFEF00D, 64);
        send_frame(-1, 1'b0, 1'b0, 64);
        end_frame(); idle(4);
        check("postreset_nvalid", n_valid, 32'd3);
        check("postreset_data",   rx_data, 32'hCAFEF00D);
`ifdef RX_STATS_EN
        check("postreset_good", {16'b0, good_cnt}, 32'd1);
`else
        check("postreset_good", {16'b0, good_cnt}, 32'd0);
`endif
        check("postreset_errc", {16'b0, err_cnt}, 32'd0);

        // Bad preamble 5 5 A, then a good frame after one idle cycle.
        nib(1'b1, 1'b0, 4'h5);
        nib(1'b1, 1'b0, 4'h5);
        nib(1'b1, 1'b0, 4'hA);
        for (int i = 0; i < 3; i++) nib(1'b1, 1'b0, 4'h3);
        end_frame();
        build(0, 16'd1024, 32'h11223344, 64);
        send_frame(-1, 1'b0, 1'b0, 64);
        end_frame(); idle(4);
        check("badpre_nvalid", n_valid, 32'd4);
        check("badpre_nerr",   n_err,   32'd5);
        check("badpre_data",   rx_data, 32'h11223344);

        // Back-to-back: errored frame, one idle cycle, good frame.
        send_frame(-1, 1'b1, 1'b0, 64);
        end_frame();
        build(0, 16'd1024, 32'h55667788, 64);
        send_frame(-1, 1'b0, 1'b0, 64);
        end_frame(); idle(4);
        check("b2b_nerr",   n_err,   32'd6);
        check("b2b_nvalid", n_valid, 32'd5);
        check("b2b_data",   rx_data, 32'h55667788);
`ifdef RX_STATS_EN
        check("stats_good_b", {16'b0, good_cnt}, 32'd3);
        check("stats_err_b",  {16'b0, err_cnt},  32'd1);
`else
        check("stats_good_b", {16'b0, good_cnt}, 32'd0);
        check("stats_err_b",  {16'b0, err_cnt},  32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mii_udp_receiver.md
MII_UDP_RECEIVER -- requirements
Module: mii_udp_receiver

Interface
REQ-001 SHALL have parameter MyMAC, 48'h123456789ABC, unicast destination MAC accepted; 48'hFFFFFFFFFFFF is always accepted too.
REQ-002 SHALL have parameter MyIP, 32'hC0A82518 (192.168.37.24), required IPv4 destination address.
REQ-003 SHALL have parameter UDPport, 16'd1024, required UDP destination port.
REQ-004 SHALL have port i_clk  input  1  25MHz MII RX_CLK domain, the only clock.
REQ-005 SHALL have port i_res_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port i_mii_rx_dv  input  1  MII RX_DV.
REQ-007 SHALL have port i_mii_rx_er  input  1  MII RX_ER.
REQ-008 SHALL have port i_mii_rxd  input  4  MII RXD, low nibble of each byte first.
REQ-009 SHALL have port o_rx_valid  output  1  1-clk pulse: accepted frame, payload on o_rx_data.
REQ-010 SHALL have port o_rx_data  output  32  first 4 UDP payload bytes; byte 42 in [31:24] through byte 45 in [7:0].
REQ-011 SHALL have port o_rx_err  output  1  1-clk pulse: errored frame.
REQ-012 SHALL have port o_good_cnt  output  16  accepted-frame count (see Configuration).
REQ-013 SHALL have port o_err_cnt  output  16  errored-frame count (see Configuration).

Function
REQ-014 SHALL use FSM states IDLE, PREAMBLE, DATA, DROP.
REQ-015 SHALL go IDLE->PREAMBLE when rx_dv=1 and rxd=4'h5.
REQ-016 SHALL go IDLE->DROP when rx_dv=1 and rxd!=4'h5.
REQ-017 SHALL, in PREAMBLE, stay on 4'h5, go to DATA on 4'hD, go to DROP on any other nibble, and go to IDLE on rx_dv=0 with no pulse.
REQ-018 SHALL go DROP->IDLE on rx_dv=0 with no pulse.
REQ-019 SHALL, in DATA, assemble bytes from nibble pairs (first nibble -> [3:0]) and count bytes from 0 (first destination MAC byte), with an 11-bit counter.
REQ-020 SHALL run CRC-32 (poly 04C11DB7, reflected/LSB-first, seed FFFFFFFF) over every DATA nibble, FCS included; FCS is good when the register equals 32'hDEBB20E3.
REQ-021 SHALL require these header fields: bytes 0-5 = MyMAC or broadcast; 12-13 = 08 00; 14 = 45; 23 = 11; 30-33 = MyIP; 36-37 = UDPport.
REQ-022 SHALL latch payload bytes 42-45 into a shadow register.
REQ-023 SHALL end the frame on the first clock that samples rx_dv=0 in DATA, then go to IDLE.
REQ-024 SHALL, on the next edge after frame end, pulse exactly one of o_rx_valid / o_rx_err, or neither.
REQ-025 SHALL pulse o_rx_err if rx_er was seen in DATA, or the nibble count is odd, or bytes < 64, or bytes > 1518, or the FCS is bad.
REQ-026 SHALL, at the 1519th byte, enter DROP and flag the frame oversize; o_rx_err pulses after rx_dv falls.
REQ-027 SHALL pulse o_rx_valid for error-free frames that pass all REQ-021 fields; o_rx_data updates on the same edge from the shadow register.
REQ-028 SHALL silently drop error-free frames that fail any REQ-021 field (no pulse).
REQ-029 SHALL hold o_rx_data until the next o_rx_valid.
REQ-030 SHALL have 1-cycle latency from the first rx_dv=0 sample to the pulse.
REQ-031 SHALL, on back-to-back frames (1 idle cycle), handle the result pulse and the new preamble nibble independently.

Reset
REQ-032 SHALL, on i_res_n=0, immediately force state=IDLE, o_rx_valid=0, o_rx_err=0, o_rx_data=0, o_good_cnt=0, o_err_cnt=0, CRC=FFFFFFFF, byte counter=0.
REQ-033 SHALL abort a frame in progress at reset with no pulse; if rx_dv is high at reset release, a mid-frame nibble leads to DROP.

Configuration
REQ-034 SHALL, with RX_STATS_EN defined, increment o_good_cnt on each o_rx_valid and o_err_cnt on each o_rx_err; both saturate at 16'hFFFF.
REQ-035 SHALL, without RX_STATS_EN, drive o_good_cnt and o_err_cnt constant 0 and implement no counter flops.

Verification
REQ-036 SHALL cover: 7x5+D, 64-byte broadcast frame to 192.168.37.24:1024, payload DE AD BE EF, good FCS -> o_rx_valid 1 clk, o_rx_data=32'hDEADBEEF, o_rx_err=0.
REQ-037 SHALL cover: same frame with the last FCS nibble flipped -> o_rx_err pulse, o_rx_valid=0, o_rx_data unchanged.
REQ-038 SHALL cover: good frame with UDP port 1025 -> no pulse; good frame with rx_er high for 1 cycle at byte 20 -> o_rx_err.
REQ-039 SHALL cover: 60-byte runt, then 1600-byte frame, then 129-nibble frame -> three o_rx_err pulses; with RX_STATS_EN o_err_cnt=3.
REQ-040 SHALL cover: i_res_n low at byte 30, released, then a good frame -> only one o_rx_valid (the second frame), o_good_cnt=1.
REQ-041 SHALL cover: preamble 5 5 A -> DROP until rx_dv=0, no pulse; then a good frame after 1 idle cycle -> o_rx_valid.
